// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - Gray/binary pointer helpers shared by both FIFO pointer controllers.
package fifo_pkg;

  // Widest pointer supported: ADDRESS_WIDTH up to 16 plus the wrap bit.
  localparam int PTR_MAX_W = 17;

  typedef logic [PTR_MAX_W-1:0] ptr_t;

  // Callers zero-extend into ptr_t and truncate the result.
  // Leading zeros leave both conversions unchanged.
  function automatic ptr_t bin2gray(input ptr_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t gray);
    ptr_t bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// rtl/fifo_gray2bin.sv - Width-parametrised Gray-to-binary converter, shared with the read-side level logic.
module fifo_gray2bin
  import fifo_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  assign bin = W'(gray2bin(ptr_t'(gray)));

endmodule

// File: rtl/fifo_wr_ptr_ctrl.sv
// rtl/fifo_wr_ptr_ctrl.sv - Async FIFO write-side pointer, full/almost-full/level and sticky overflow.
module fifo_wr_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 3
) (
  input  logic                   W_CLK,
  input  logic                   W_RST,
  input  logic                   W_INC,
  input  logic [ADDRESS_WIDTH:0] SYNC_RD_PTR,
  input  logic [ADDRESS_WIDTH:0] AF_THRESH,
  input  logic                   OVF_CLR,
  output logic                   WR_EN,
  output logic [ADDRESS_WIDTH-1:0] WR_ADDR,
  output logic [ADDRESS_WIDTH:0] WR_PTR,
  output logic                   FULL,
  output logic                   ALMOST_FULL,
  output logic [ADDRESS_WIDTH:0] FILL_LEVEL,
  output logic                   OVERFLOW
);

  localparam int PTR_W = ADDRESS_WIDTH + 1;

  logic [ADDRESS_WIDTH:0] wr_bin;
  logic [ADDRESS_WIDTH:0] wr_bin_next;
  logic [ADDRESS_WIDTH:0] wr_gray_next;
  logic [ADDRESS_WIDTH:0] rd_bin;
  logic                   overflow_q;

  fifo_gray2bin #(.W(PTR_W)) u_rd_gray2bin (
    .gray (SYNC_RD_PTR),
    .bin  (rd_bin)
  );

  // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
  assign FULL  = (WR_PTR == {~SYNC_RD_PTR[ADDRESS_WIDTH:ADDRESS_WIDTH-1],
                             SYNC_RD_PTR[ADDRESS_WIDTH-2:0]});
  assign WR_EN = W_INC & ~FULL;

  assign wr_bin_next  = WR_EN ? wr_bin + PTR_W'(1) : wr_bin;
  assign wr_gray_next = PTR_W'(bin2gray(ptr_t'(wr_bin_next)));

  always_ff @(posedge W_CLK or posedge W_RST) begin
    if (W_RST) begin
      wr_bin <= '0;
      WR_PTR <= '0;
    end else begin
      wr_bin <= wr_bin_next;
      WR_PTR <= wr_gray_next;
    end
  end

  // A rejected push outranks a same-cycle clear so no overflow event is lost.
  always_ff @(posedge W_CLK or posedge W_RST) begin
    if (W_RST) begin
      overflow_q <= 1'b0;
    end else if (W_INC && FULL) begin
      overflow_q <= 1'b1;
    end else if (OVF_CLR) begin
      overflow_q <= 1'b0;
    end
  end

  assign WR_ADDR     = wr_bin[ADDRESS_WIDTH-1:0];
  assign FILL_LEVEL  = wr_bin - rd_bin;
  assign ALMOST_FULL = (FILL_LEVEL >= AF_THRESH);
  assign OVERFLOW    = overflow_q;

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// tb/tb_fifo_wr_ptr_ctrl.sv - Directed self-checking bench for fifo_wr_ptr_ctrl with ADDRESS_WIDTH=3.
module tb_fifo_wr_ptr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       inc;
  logic [3:0] sync_rd_ptr;
  logic [3:0] af_thresh;
  logic       ovf_clr;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_ptr;
  logic       full;
  logic       almost_full;
  logic [3:0] fill_level;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  fifo_wr_ptr_ctrl #(.ADDRESS_WIDTH(3)) dut (
    .W_CLK       (clk),
    .W_RST       (rst),
    .W_INC       (inc),
    .SYNC_RD_PTR (sync_rd_ptr),
    .AF_THRESH   (af_thresh),
    .OVF_CLR     (ovf_clr),
    .WR_EN       (wr_en),
    .WR_ADDR     (wr_addr),
    .WR_PTR      (wr_ptr),
    .FULL        (full),
    .ALMOST_FULL (almost_full),
    .FILL_LEVEL  (fill_level),
    .OVERFLOW    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] gray4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [3:0] exp_ptr [8];
  logic [3:0] wbin;

  initial begin
    exp_ptr = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
    rst = 1'b1; inc = 1'b0; sync_rd_ptr = '0; af_thresh = 4'd6; ovf_clr = 1'b0;
    tick(); tick();

    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_ptr", wr_ptr, 0);
    check("rst_overflow", overflow, 0);
    check("rst_full", full, 0);
    check("rst_fill", fill_level, 0);
    check("rst_af", almost_full, 0);
    rst = 1'b0;

    // Fill from empty; almost-full rises exactly at level 6
    for (int i = 0; i < 8; i++) begin
      inc = 1'b1;
      #1;
      check("push_wr_en", wr_en, 1);
      tick();
      check("push_wr_ptr", wr_ptr, exp_ptr[i]);
      check("push_fill", fill_level, i + 1);
      check("push_wr_addr", wr_addr, (i + 1) % 8);
      check("push_af", almost_full, (i + 1) >= 6);
    end
    check("full_after_8", full, 1);
    check("fill_after_8", fill_level, 8);
    check("wr_en_when_full", wr_en, 0);

    // Rejected pushes while full
    tick();
    check("ovf_set", overflow, 1);
    check("ovf_ptr_hold1", wr_ptr, 4'b1100);
    tick();
    check("ovf_ptr_hold2", wr_ptr, 4'b1100);
    check("ovf_addr_hold", wr_addr, 0);
    inc = 1'b0; ovf_clr = 1'b1;
    tick();
    check("ovf_clr", overflow, 0);
    inc = 1'b1;
    tick();
    check("ovf_set_wins", overflow, 1);
    check("ovf_ptr_hold3", wr_ptr, 4'b1100);
    inc = 1'b0;
    tick();
    check("ovf_clr2", overflow, 0);
    ovf_clr = 1'b0;

    // Read-side advance frees one slot in the same cycle
    sync_rd_ptr = 4'b0001;
    #1;
    check("rd_adv_full", full, 0);
    check("rd_adv_fill", fill_level, 7);
    check("rd_adv_wr_en_idle", wr_en, 0);
    inc = 1'b1;
    tick();
    inc = 1'b0;
    check("refill_ptr", wr_ptr, 4'b1101);
    check("refill_full", full, 1);
    check("refill_fill", fill_level, 8);

    af_thresh = 4'd0;
    #1;
    check("af_thresh0", almost_full, 1);
    af_thresh = 4'd9;
    #1;
    check("af_thresh9", almost_full, 0);
    af_thresh = 4'd6;

    // Wrap-around with read pointer trailing by 2
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wbin = 4'd0;
    sync_rd_ptr = gray4(wbin - 4'd2);
    #1;
    check("wrap_start_fill", fill_level, 2);
    check("wrap_start_full", full, 0);
    for (int i = 0; i < 16; i++) begin
      inc = 1'b1;
      tick();
      wbin = wbin + 4'd1;
      check("wrap_ptr", wr_ptr, gray4(wbin));
      sync_rd_ptr = gray4(wbin - 4'd2);
      #1;
      check("wrap_full", full, 0);
      check("wrap_fill", fill_level, 2);
    end
    inc = 1'b0;
    check("wrap_ptr_home", wr_ptr, 4'b0000);
    check("wrap_addr_home", wr_addr, 0);

    // Asynchronous reset mid-burst at level 5, with a push in flight
    sync_rd_ptr = gray4(4'd11);
    #1;
    check("pre_rst_fill", fill_level, 5);
    inc = 1'b1;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_addr", wr_addr, 0);
    check("async_rst_ptr", wr_ptr, 0);
    check("async_rst_ovf", overflow, 0);
    tick();
    check("rst_discard_push", wr_ptr, 0);
    inc = 1'b0;
    sync_rd_ptr = '0;
    #2;
    rst = 1'b0;
    inc = 1'b1;
    tick();
    inc = 1'b0;
    check("post_rst_ptr", wr_ptr, 4'b0001);
    check("post_rst_fill", fill_level, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
